// File: rtl/tx_axis_frame_streamer_if.sv
// ---------------------------------------------------------------------------
// tx_axis_frame_streamer_if
//   AXI-Stream bundle between the TX frame streamer and the MAC.
//   tdata  [63:0]  frame qword, byte 0 in [7:0]
//   tstrb  [7:0]   byte enables, 8'hFF except on the last beat
//   tuser  [127:0] [31:0] frame byte count, [127:32] zero
//   tvalid         beat valid
//   tlast          last beat of frame
//   tready         MAC accepts beat
//   master modport: streamer side; slave modport: MAC side.
// ---------------------------------------------------------------------------
interface tx_axis_frame_streamer_if;
  logic [63:0]  tdata;
  logic [7:0]   tstrb;
  logic [127:0] tuser;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/tx_axis_frame_streamer.sv
// ---------------------------------------------------------------------------
// tx_axis_frame_streamer
//   Reads length-prefixed frames from the TX ring (64-bit qwords, read latency
//   RD_LAT) and streams them to the MAC over AXI-Stream, then releases the
//   consumed ring space back to the writer one frame at a time.
// Ports
//   clk, reset_n             clock, synchronous active-low reset
//   m_axis                   AXI-Stream master (tdata/tstrb/tuser/tvalid/tlast/tready)
//   rd_addr / rd_data        ring read port, data RD_LAT cycles after address
//   commited_rd_addr(_change) released read pointer and its 1-cycle update pulse
//   commited_wr_addr(_change) writer pointer and its foreign-domain strobe
//   frames_sent              sent-frame counter, present only when the
//                            TX_FRAME_COUNTER_EN macro is defined
// ---------------------------------------------------------------------------
module tx_axis_frame_streamer #(
  parameter int AW        = 10,
  parameter int RD_LAT    = 1,
  parameter int MAX_BYTES = 9600
) (
  input  logic                      clk,
  input  logic                      reset_n,
  tx_axis_frame_streamer_if.master  m_axis,
  output logic [AW-1:0]             rd_addr,
  input  logic [63:0]               rd_data,
  output logic [AW-1:0]             commited_rd_addr,
  output logic                      commited_rd_addr_change,
  input  logic                      commited_wr_addr_change,
  input  logic [AW-1:0]             commited_wr_addr
`ifdef TX_FRAME_COUNTER_EN
  ,
  output logic [31:0]               frames_sent
`endif
);

  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_CHECK = 3'd2,
    S_STRM  = 3'd3,
    S_DONE  = 3'd4,
    S_DROP  = 3'd5
  } state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] rd_ptr_r, rd_addr_r, commit_addr_r, new_ptr_s, avail_s;
  logic [AW-1:0] wr_q_r, wr_sync_r;
  logic          stb_meta_r, stb_sync_r, commit_pend_r, commit_chg_r;
  logic [31:0]   len_r;
  logic [29:0]   nq_r, rd_left_r, push_left_r;
  logic [7:0]    strb_last_r;
  logic [RD_LAT-1:0] pipe_r;
  logic [1:0]    inflight_s, cnt_r, cnt_s;
  logic [63:0]   d0_r, d1_r;
  logic [7:0]    s0_r, s1_r, push_strb_s;
  logic          l0_r, l1_r, push_last_s, tvalid_r;
  logic          data_vld_s, push_s, pop_s, fits_s, bad_len_s, strm_ok_s;
  logic          hdr_issue_s, strm_issue_s, hdr_take_s, strm_start_s, commit_s;

  assign avail_s    = wr_sync_r - rd_ptr_r;
  assign data_vld_s = pipe_r[RD_LAT-1];
  assign pop_s      = tvalid_r & m_axis.tready;
  assign push_s     = (state_r == S_STRM) & data_vld_s;
  assign fits_s     = 32'(avail_s) >= (32'd1 + {2'b00, nq_r});
  assign bad_len_s  = (len_r == 32'd0) || (len_r > 32'(MAX_BYTES));
  assign push_last_s = (push_left_r == 30'd1);
  assign push_strb_s = push_last_s ? strb_last_r : 8'hFF;
  assign cnt_s      = cnt_r + {1'b0, push_s} - {1'b0, pop_s};

  // Reads in flight plus FIFO occupancy never exceed two entries; the slot
  // freed by this cycle's pop is credited so 1 beat/cycle is sustained.
  always_comb begin
    inflight_s = 2'd0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_s = inflight_s + {1'b0, pipe_r[i]};
    end
    strm_ok_s = (rd_left_r != 30'd0) &&
                (({1'b0, cnt_r} + {1'b0, inflight_s}) < (3'd2 + {2'b00, pop_s}));
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and control strobes
  always_comb begin
    state_s      = state_r;
    hdr_issue_s  = 1'b0;
    strm_issue_s = 1'b0;
    hdr_take_s   = 1'b0;
    strm_start_s = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (avail_s != {AW{1'b0}}) begin
          hdr_issue_s = 1'b1;
          state_s     = S_HDR;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HDR: begin
        if (data_vld_s) begin
          hdr_take_s = 1'b1;
          state_s    = S_CHECK;
        end else begin
          state_s = S_HDR;
        end
      end
      S_CHECK: begin
        if (bad_len_s) begin
          state_s = S_DROP;
        end else if (fits_s) begin
          strm_start_s = 1'b1;
          state_s      = S_STRM;
        end else begin
          state_s = S_CHECK;
        end
      end
      S_STRM: begin
        strm_issue_s = strm_ok_s;
        if (pop_s && l0_r) begin
          state_s = S_DONE;
        end else begin
          state_s = S_STRM;
        end
      end
      S_DONE:  begin commit_s = 1'b1; state_s = S_IDLE; end
      S_DROP:  begin commit_s = 1'b1; state_s = S_IDLE; end
      default: state_s = S_IDLE;
    endcase
  end

  // Pointer that the ring is released up to after this frame
  always_comb begin
    if (state_r == S_DONE) begin
      new_ptr_s = rd_ptr_r + AW'(nq_r) + ONE_A;
    end else begin
      new_ptr_s = rd_ptr_r + ONE_A;
    end
  end

  // Writer pointer synchroniser: strobe through two flops, address captured once
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stb_meta_r <= 1'b0;
      stb_sync_r <= 1'b0;
      wr_q_r     <= {AW{1'b0}};
      wr_sync_r  <= {AW{1'b0}};
    end else begin
      stb_meta_r <= commited_wr_addr_change;
      stb_sync_r <= stb_meta_r;
      wr_q_r     <= commited_wr_addr;
      if (stb_sync_r) begin
        wr_sync_r <= wr_q_r;
      end
    end
  end

  // Read address, frame header, counters and commit handshake
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_r      <= {AW{1'b0}};
      rd_addr_r     <= {AW{1'b0}};
      commit_addr_r <= {AW{1'b0}};
      commit_pend_r <= 1'b0;
      commit_chg_r  <= 1'b0;
      len_r         <= 32'd0;
      nq_r          <= 30'd0;
      strb_last_r   <= 8'h00;
      rd_left_r     <= 30'd0;
      push_left_r   <= 30'd0;
      pipe_r        <= {RD_LAT{1'b0}};
    end else begin
      // rd_addr_r always points at the next unread qword, so an issue is
      // simply "consume the address currently presented".
      if (commit_s) begin
        rd_ptr_r      <= new_ptr_s;
        rd_addr_r     <= new_ptr_s;
        commit_addr_r <= new_ptr_s;
      end else if (hdr_issue_s || strm_issue_s) begin
        rd_addr_r <= rd_addr_r + ONE_A;
      end
      commit_pend_r <= commit_s;
      commit_chg_r  <= commit_pend_r;
      pipe_r[0]     <= hdr_issue_s | strm_issue_s;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
      if (hdr_take_s) begin
        len_r       <= rd_data[63:32];
        nq_r        <= 30'(({1'b0, rd_data[63:32]} + 33'd7) >> 3);
        strb_last_r <= (rd_data[34:32] == 3'd0) ? 8'hFF
                                                : ((8'h01 << rd_data[34:32]) - 8'h01);
      end
      if (strm_start_s) begin
        rd_left_r   <= nq_r;
        push_left_r <= nq_r;
      end else begin
        if (strm_issue_s) begin
          rd_left_r <= rd_left_r - 30'd1;
        end
        if (push_s) begin
          push_left_r <= push_left_r - 30'd1;
        end
      end
    end
  end

  // Two-entry skid FIFO; entry 0 drives the AXIS beat directly
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d0_r <= 64'd0;  d1_r <= 64'd0;
      s0_r <= 8'h00;  s1_r <= 8'h00;
      l0_r <= 1'b0;   l1_r <= 1'b0;
      cnt_r    <= 2'd0;
      tvalid_r <= 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            d0_r <= rd_data; s0_r <= push_strb_s; l0_r <= push_last_s;
          end else begin
            d1_r <= rd_data; s1_r <= push_strb_s; l1_r <= push_last_s;
          end
        end
        2'b01: begin
          d0_r <= d1_r; s0_r <= s1_r; l0_r <= l1_r;
        end
        2'b11: begin
          if (cnt_r == 2'd1) begin
            d0_r <= rd_data; s0_r <= push_strb_s; l0_r <= push_last_s;
          end else begin
            d0_r <= d1_r;    s0_r <= s1_r;        l0_r <= l1_r;
            d1_r <= rd_data; s1_r <= push_strb_s; l1_r <= push_last_s;
          end
        end
        default: begin
        end
      endcase
      cnt_r    <= cnt_s;
      tvalid_r <= (cnt_s != 2'd0);
    end
  end

`ifdef TX_FRAME_COUNTER_EN
  logic [31:0] frames_sent_r;

  // Count frames that completed on the stream; dropped headers do not count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frames_sent_r <= 32'd0;
    end else if (state_r == S_DONE) begin
      frames_sent_r <= frames_sent_r + 32'd1;
    end
  end

  assign frames_sent = frames_sent_r;
`endif

  assign m_axis.tdata  = d0_r;
  assign m_axis.tstrb  = s0_r;
  assign m_axis.tlast  = l0_r;
  assign m_axis.tvalid = tvalid_r;
  assign m_axis.tuser  = {96'd0, len_r};
  assign rd_addr                 = rd_addr_r;
  assign commited_rd_addr        = commit_addr_r;
  assign commited_rd_addr_change = commit_chg_r;

endmodule

// File: tb/tb_tx_axis_frame_streamer.sv
module tb_tx_axis_frame_streamer;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic [AW-1:0] commited_rd_addr;
  logic          commited_rd_addr_change;
  logic          commited_wr_addr_change;
  logic [AW-1:0] commited_wr_addr;
`ifdef TX_FRAME_COUNTER_EN
  logic [31:0]   frames_sent;
`endif

  tx_axis_frame_streamer_if axis_if ();

  tx_axis_frame_streamer #(.AW(AW), .RD_LAT(1), .MAX_BYTES(9600)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .m_axis                  (axis_if),
    .rd_addr                 (rd_addr),
    .rd_data                 (rd_data),
    .commited_rd_addr        (commited_rd_addr),
    .commited_rd_addr_change (commited_rd_addr_change),
    .commited_wr_addr_change (commited_wr_addr_change),
    .commited_wr_addr        (commited_wr_addr)
`ifdef TX_FRAME_COUNTER_EN
    ,
    .frames_sent             (frames_sent)
`endif
  );

  always #5 clk = ~clk;

  // Ring RAM model, one cycle read latency
  logic [63:0] mem [DEPTH];
  always @(posedge clk) rd_data <= mem[rd_addr];

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [31:0] len;
  } beat_t;

  typedef struct {
    int len;
    int rdy;
    int exp_beats;
    int exp_commit;
  } vec_t;

  beat_t         exp_q[$];
  logic [AW-1:0] commit_q[$];
  int checks = 0, errors = 0;
  int beat_cnt = 0, gap_cnt = 0, commit_cnt = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [AW-1:0] v);
    commited_wr_addr        = v;
    commited_wr_addr_change = 1'b1;
    tick(3);
    commited_wr_addr_change = 1'b0;
    tick(1);
  endtask

  task automatic wait_commits(input int target);
    int n;
    n = 0;
    while (commit_cnt < target && n < 3000) begin
      tick(1);
      n++;
    end
    chk("commit_timeout", 128'(commit_cnt >= target), 128'd1);
  endtask

  // Writes header + payload at 'at' and queues the beats the MAC must see
  task automatic put_frame(input logic [AW-1:0] at, input int len);
    int nq, rem;
    logic [AW-1:0] a;
    logic [63:0] w;
    logic [7:0] ff;
    beat_t b;
    mem[at] = {len[31:0], $urandom()};
    if (len > 0 && len <= 9600) begin
      nq  = (len + 7) / 8;
      rem = len % 8;
      ff  = 8'hFF;
      for (int i = 1; i <= nq; i++) begin
        a      = at + AW'(i);
        w      = {$urandom(), $urandom()};
        mem[a] = w;
        b.data = w;
        b.last = (i == nq);
        b.strb = (i == nq && rem != 0) ? (ff >> (8 - rem)) : 8'hFF;
        b.len  = len[31:0];
        exp_q.push_back(b);
      end
    end
  endtask

  // tready driver: 0 = always ready, 1 = random 50%, other = never
  initial begin
    axis_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       axis_if.tready = 1'b1;
        1:       axis_if.tready = 1'($urandom_range(0, 1));
        default: axis_if.tready = 1'b0;
      endcase
    end
  end

  // Monitor: sampled on the falling edge, scoreboard pop per accepted beat
  initial begin
    beat_t e;
    logic prev_stall, in_frame, prev_chg, prev_last;
    logic [63:0] prev_data;
    logic [7:0] prev_strb;
    prev_stall = 1'b0; in_frame = 1'b0; prev_chg = 1'b0;
    prev_data = 64'd0; prev_strb = 8'd0; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0; in_frame = 1'b0; prev_chg = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!axis_if.tvalid || axis_if.tdata !== prev_data ||
              axis_if.tstrb !== prev_strb || axis_if.tlast !== prev_last) begin
            errors++;
            $display("FAIL hold: tvalid=%0b tdata=%h tstrb=%h tlast=%0b required held tdata=%h tstrb=%h tlast=%0b",
                     axis_if.tvalid, axis_if.tdata, axis_if.tstrb, axis_if.tlast,
                     prev_data, prev_strb, prev_last);
          end
        end
        if (in_frame && !axis_if.tvalid) gap_cnt++;
        if (axis_if.tvalid) in_frame = 1'b1;
        if (axis_if.tvalid && axis_if.tready) begin
          beat_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat: got tdata=%h with no beat required", axis_if.tdata);
          end else begin
            e = exp_q.pop_front();
            if (axis_if.tdata !== e.data || axis_if.tstrb !== e.strb ||
                axis_if.tlast !== e.last || axis_if.tuser !== {96'd0, e.len}) begin
              errors++;
              $display("FAIL beat: got %h/%h/%0b/%0d required %h/%h/%0b/%0d",
                       axis_if.tdata, axis_if.tstrb, axis_if.tlast, axis_if.tuser,
                       e.data, e.strb, e.last, e.len);
            end
          end
          if (axis_if.tlast) in_frame = 1'b0;
        end
        prev_stall = axis_if.tvalid && !axis_if.tready;
        prev_data  = axis_if.tdata;
        prev_strb  = axis_if.tstrb;
        prev_last  = axis_if.tlast;
        if (commited_rd_addr_change) begin
          commit_cnt++;
          checks++;
          if (commit_q.size() == 0 || prev_chg || commited_rd_addr !== commit_q[0]) begin
            errors++;
            $display("FAIL commit: got addr %0d (pulse_prev=%0b) required %0d",
                     commited_rd_addr, prev_chg,
                     (commit_q.size() == 0) ? -1 : int'(commit_q[0]));
          end
          if (commit_q.size() != 0) void'(commit_q.pop_front());
        end
        prev_chg = commited_rd_addr_change;
      end
    end
  end

  initial begin
    vec_t tbl[8];
    logic [AW-1:0] ptr;
    int ncommit, b0, g0, c0, n;

    tbl[0] = '{64,   0, 8,   9};
    tbl[1] = '{61,   0, 8,   18};
    tbl[2] = '{256,  1, 32,  51};
    tbl[3] = '{0,    0, 0,   52};
    tbl[4] = '{9601, 0, 0,   53};
    tbl[5] = '{1500, 0, 188, 242};
    tbl[6] = '{96,   0, 12,  255};
    tbl[7] = '{24,   0, 3,   3};

    for (int i = 0; i < DEPTH; i++) mem[i] = 64'd0;
    reset_n = 1'b0;
    commited_wr_addr_change = 1'b0;
    commited_wr_addr = '0;
    tick(3);
    chk("rst_tvalid", 128'(axis_if.tvalid), 128'd0);
    chk("rst_tlast",  128'(axis_if.tlast), 128'd0);
    chk("rst_tdata",  128'(axis_if.tdata), 128'd0);
    chk("rst_tuser",  axis_if.tuser, 128'd0);
    chk("rst_rd_addr", 128'(rd_addr), 128'd0);
    chk("rst_commit_addr", 128'(commited_rd_addr), 128'd0);
    chk("rst_commit_chg", 128'(commited_rd_addr_change), 128'd0);
    reset_n = 1'b1;
    tick(2);

    ptr = '0;
    ncommit = 0;
    for (int i = 0; i < 8; i++) begin
      put_frame(ptr, tbl[i].len);
      commit_q.push_back(AW'(tbl[i].exp_commit));
      rdy_mode = tbl[i].rdy;
      b0 = beat_cnt;
      g0 = gap_cnt;
      set_wr(AW'(tbl[i].exp_commit));
      ncommit++;
      wait_commits(ncommit);
      chk($sformatf("beats_len%0d", tbl[i].len), 128'(beat_cnt - b0), 128'(tbl[i].exp_beats));
      chk($sformatf("gaps_len%0d", tbl[i].len), 128'(gap_cnt - g0), 128'd0);
      chk($sformatf("commit_len%0d", tbl[i].len), 128'(commited_rd_addr), 128'(tbl[i].exp_commit));
      rdy_mode = 0;
      ptr = AW'(tbl[i].exp_commit);
    end
`ifdef TX_FRAME_COUNTER_EN
    chk("frames_sent_table", 128'(frames_sent), 128'd6);
`endif

    // One qword short of a full L=40 frame: must stall, then go when complete
    put_frame(ptr, 40);
    commit_q.push_back(AW'(9));
    b0 = beat_cnt;
    c0 = commit_cnt;
    set_wr(AW'(8));
    tick(40);
    chk("short_no_beats", 128'(beat_cnt - b0), 128'd0);
    chk("short_tvalid", 128'(axis_if.tvalid), 128'd0);
    chk("short_no_commit", 128'(commit_cnt - c0), 128'd0);
    set_wr(AW'(9));
    ncommit++;
    wait_commits(ncommit);
    chk("short_beats", 128'(beat_cnt - b0), 128'd5);
    chk("short_commit", 128'(commited_rd_addr), 128'd9);
`ifdef TX_FRAME_COUNTER_EN
    chk("frames_sent_short", 128'(frames_sent), 128'd7);
`endif

    // Reset in the middle of an L=256 frame
    ptr = AW'(9);
    put_frame(ptr, 256);
    b0 = beat_cnt;
    set_wr(AW'(42));
    n = 0;
    while (beat_cnt - b0 < 5 && n < 500) begin
      tick(1);
      n++;
    end
    chk("midrst_started", 128'(beat_cnt - b0 >= 5), 128'd1);
    reset_n = 1'b0;
    tick(1);
    chk("midrst_tvalid", 128'(axis_if.tvalid), 128'd0);
    chk("midrst_commit_addr", 128'(commited_rd_addr), 128'd0);
    chk("midrst_rd_addr", 128'(rd_addr), 128'd0);
    chk("midrst_commit_chg", 128'(commited_rd_addr_change), 128'd0);
    exp_q.delete();
    commit_q.delete();
    reset_n = 1'b1;
    c0 = commit_cnt;
    b0 = beat_cnt;
    tick(20);
    chk("midrst_no_commit", 128'(commit_cnt - c0), 128'd0);
    chk("midrst_no_beats", 128'(beat_cnt - b0), 128'd0);
`ifdef TX_FRAME_COUNTER_EN
    chk("frames_sent_rst", 128'(frames_sent), 128'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
